// File: rtl/ram_dump_streamer_pkg.sv
// Shared types and constants for the RAM dump streamer: state encoding,
// RAM control codes and the length clamp helper.
package ram_dump_streamer_pkg;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_LEN = 512;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic       RW_READ   = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requests longer than the RAM are trimmed to one full pass.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/ram_dump_streamer.sv
// Walks a byte range of the data RAM and streams each byte out over a
// valid/ready interface, holding the CPU off the RAM port while busy.
module ram_dump_streamer
    import ram_dump_streamer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              ram_en,
    output logic              ram_rw,
    output logic              ram_se,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic              last_q, last_d;
    logic              busy_q, done_q, ram_en_q, valid_q;

    // Only the low byte of the RAM word is streamed.
    logic unused_dout;
    assign unused_dout = ^ram_dout[DATA_W-1:8];

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        cur_d   = base_addr;
                        cnt_d   = clamp_len(length);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                data_d  = ram_dout[7:0];
                oaddr_d = cur_q;
                last_d  = (cnt_q == LEN_W'(1));
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = cur_q + ADDR_W'(1);
                        cnt_d   = cnt_q - LEN_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // alongside the state itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            oaddr_q  <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ram_en_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            oaddr_q  <= oaddr_d;
            last_q   <= last_d;
            busy_q   <= (state_d == ST_FETCH) || (state_d == ST_HOLD);
            done_q   <= (state_d == ST_DONE);
            ram_en_q <= (state_d == ST_FETCH);
            valid_q  <= (state_d == ST_HOLD);
        end
    end

    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign ram_en    = ram_en_q;
    assign ram_rw    = RW_READ;
    assign ram_se    = 1'b0;
    assign ram_size  = SIZE_BYTE;
    assign ram_addr  = cur_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = oaddr_q;
    assign out_last  = last_q;

endmodule
